// File: rtl/risc8_run_pkg.sv
// rtl/risc8_run_pkg.sv - shared state encodings and helpers for the risc8 run-control sequencer
package risc8_run_pkg;

    // State codes, also used by the debug interface for status reads
    localparam logic [1:0] ST_HOLD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;
    localparam logic [1:0] ST_STEP = 2'd3;

    typedef enum logic [1:0] {
        S_HOLD = ST_HOLD,
        S_RUN  = ST_RUN,
        S_HALT = ST_HALT,
        S_STEP = ST_STEP
    } run_state_t;

    // Counter width able to hold 0..n-1, never less than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/risc8_run_ctrl_if.sv
// rtl/risc8_run_ctrl_if.sv - request/status bundle between a debug host and the run-control sequencer
interface risc8_run_ctrl_if;

    logic       halt_req;
    logic       run_req;
    logic       step_req;
    logic       rst_req;
    logic       cpu_ce;
    logic       cpu_reset;
    logic       halted;
    logic [1:0] state;

    // Host side: issues requests, observes core enable/reset and status
    modport master (
        output halt_req, run_req, step_req, rst_req,
        input  cpu_ce, cpu_reset, halted, state
    );

    // Sequencer side
    modport slave (
        input  halt_req, run_req, step_req, rst_req,
        output cpu_ce, cpu_reset, halted, state
    );

endinterface

// File: rtl/risc8_run_ctrl_prescaler.sv
// rtl/risc8_run_ctrl_prescaler.sv - free-running 0..DIV-1 prescaler with boundary strobe and sync clear
module risc8_prescaler #(
    parameter  int DIV = 8,
    localparam int W   = $clog2(DIV)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic boundary
);

    logic [W-1:0] count;

    assign boundary = (count == W'(DIV - 1));

    // Count up and wrap at DIV-1; clear wins so the sequencer can restart the phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || boundary) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/risc8_run_ctrl.sv
// rtl/risc8_run_ctrl.sv - run-control sequencer: core clock enable, reset hold, halt/resume/single-step
module risc8_run_ctrl
    import risc8_run_pkg::*;
#(
    parameter int DIV          = 8,
    parameter int RESET_HOLD   = 16,
    parameter bit START_HALTED = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    risc8_run_ctrl_if.slave  bus
);

    localparam int             HW        = cnt_width(RESET_HOLD);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(RESET_HOLD - 1);

    run_state_t    state_q;
    run_state_t    state_d;
    logic          ce_d;
    logic          cpu_ce_q;
    logic [HW-1:0] hold_cnt;
    logic          step_prev;
    logic          step_edge;
    logic          hold_done;
    logic          pre_clear;
    logic          boundary;

    assign step_edge = bus.step_req & ~step_prev;
    assign hold_done = (hold_cnt == HOLD_LAST);

    // The prescaler sits at zero through the hold so the first enable lands DIV cycles after release
    assign pre_clear = (state_q == S_HOLD) | bus.rst_req;

    risc8_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .clear    (pre_clear),
        .boundary (boundary)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and enable decision; rst_req beats halt_req beats run_req beats a step edge
    always_comb begin
        state_d = state_q;
        ce_d    = 1'b0;
        if (bus.rst_req) begin
            state_d = S_HOLD;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (hold_done) begin
                        state_d = START_HALTED ? S_HALT : S_RUN;
                    end
                end
                S_RUN: begin
                    if (boundary) begin
                        if (bus.halt_req) begin
                            state_d = S_HALT;
                        end else begin
                            ce_d = 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    if (!bus.halt_req) begin
                        if (bus.run_req) begin
                            state_d = S_RUN;
                        end else if (step_edge) begin
                            state_d = S_STEP;
                        end
                    end
                end
                S_STEP: begin
                    // halt_req is ignored here: the step always completes
                    if (boundary) begin
                        ce_d    = 1'b1;
                        state_d = S_HALT;
                    end
                end
                default: begin
                    state_d = S_HOLD;
                end
            endcase
        end
    end

    // Hold counter runs only while holding and restarts on every reset request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
        end else if (bus.rst_req || (state_q != S_HOLD) || hold_done) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // Registered enable pulse and step-request history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_ce_q  <= 1'b0;
            step_prev <= 1'b0;
        end else begin
            cpu_ce_q  <= ce_d;
            step_prev <= bus.step_req;
        end
    end

    assign bus.cpu_ce    = cpu_ce_q;
    assign bus.cpu_reset = (state_q == S_HOLD);
    assign bus.halted    = (state_q == S_HALT);
    assign bus.state     = state_q;

endmodule
